mem_fetch_ctrl: RTL and testbench

Fetch/decode/execute sequencer that acts as the initiator on the 10-bit instruction/data memory port. Each instruction word is 2-bit opcode [9:8] plus 8-bit operand [7:0]. The block drives the memory address and read strobe, captures words into IR/MBR, and executes the three load opcodes into the R and A registers. It sits between the memory array and the datapath registers of the teaching CPU.

---
 rtl/mem_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fetch_ctrl.sv
// Fetch/decode/execute sequencer for the 10-bit instruction memory port; opcode 00 halts when MEM_CTRL_HALT_EN is defined, else NOP.
// Latency: MOVR/LDI/NOP retire 2 cycles after FETCH entry, LDA 3; back-to-back with no bubble.
// Backpressure: none; memory is combinational, stop is honoured only at retire, start only in IDLE.
module mem_fetch_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [9:0] mem_data,
    output logic [7:0] mem_addr,
    output logic       mem_rw,
    output logic [7:0] pc,
    output logic [9:0] ir,
    output logic [7:0] reg_r,
    output logic [7:0] reg_a,
    output logic       busy,
    output logic       instr_done,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_pc;
    logic [9:0]  r_ir;
    logic [7:0]  r_r;
    logic [7:0]  r_a;
    logic [7:0]  r_mbr;
    logic [7:0]  w_addr;
    logic        w_done;
    logic [1:0]  w_op;

    assign w_op = r_ir[9:8];

    always_comb begin
        w_next = r_state;
        w_addr = r_pc;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_next = S_DECODE;
            end
            S_DECODE: begin
                w_addr = r_ir[7:0];
                if (w_op == 2'b11) begin
                    w_next = S_READ;
                end else begin
                    w_done = 1'b1;
                    w_next = stop ? S_IDLE : S_FETCH;
`ifdef MEM_CTRL_HALT_EN
                    if (w_op == 2'b00) w_next = S_HALT;
`endif
                end
            end
            S_READ: begin
                w_addr = r_mbr;
                w_done = 1'b1;
                w_next = stop ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
`ifdef MEM_CTRL_HALT_EN
                w_next = S_HALT;
`else
                w_next = S_IDLE;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= 8'h00;
            r_ir    <= 10'h000;
            r_r     <= 8'h00;
            r_a     <= 8'h00;
            r_mbr   <= 8'h00;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    r_ir <= mem_data;
                    r_pc <= r_pc + 8'd1;
                end
                S_DECODE: begin
                    // mem_data here is the word at the operand address
                    case (w_op)
                        2'b01:   r_r   <= r_ir[7:0];
                        2'b10:   r_a   <= mem_data[7:0];
                        2'b11:   r_mbr <= mem_data[7:0];
                        default: ;
                    endcase
                end
                S_READ: r_a <= mem_data[7:0];
                default: ;
            endcase
        end
    end

    assign mem_addr   = w_addr;
    assign mem_rw     = 1'b0;
    assign pc         = r_pc;
    assign ir         = r_ir;
    assign reg_r      = r_r;
    assign reg_a      = r_a;
    assign busy       = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_READ);
    assign instr_done = w_done;
`ifdef MEM_CTRL_HALT_EN
    assign halted     = (r_state == S_HALT);
`else
    assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Bench for mem_fetch_ctrl: vector table of retirements checked through a scoreboard queue,
// plus hand sequences for stop, halt/wrap and reset during the LDA operand read.
module tb_mem_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [9:0] mem_data;
    logic [7:0] mem_addr;
    logic       mem_rw;
    logic [7:0] pc;
    logic [9:0] ir;
    logic [7:0] reg_r;
    logic [7:0] reg_a;
    logic       busy;
    logic       instr_done;
    logic       halted;

    mem_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mem_data   (mem_data),
        .mem_addr   (mem_addr),
        .mem_rw     (mem_rw),
        .pc         (pc),
        .ir         (ir),
        .reg_r      (reg_r),
        .reg_a      (reg_a),
        .busy       (busy),
        .instr_done (instr_done),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    logic [9:0] mem [256];
    assign mem_data = mem[mem_addr];

    typedef struct {
        logic       stop;
        logic [7:0] pc;
        logic [7:0] r;
        logic [7:0] a;
        int         gap;
    } vec_t;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] r;
        logic [7:0] a;
        int         gap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[3];

    int nvec    = 0;
    int nerr    = 0;
    int cyc     = 0;
    int last_cyc = 0;
    int pgap    = 0;
    int rw_bad  = 0;
    bit pend    = 1'b0;
    bit found;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Retirement monitor: state is checked one edge after the instr_done cycle
    always @(negedge clk) begin
        if (mem_rw !== 1'b0) rw_bad++;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_retire: pc %0h with no expected entry", pc);
                end else begin
                    e = sb.pop_front();
                    check("retire_pc", {24'h0, pc}, {24'h0, e.pc});
                    check("retire_r", {24'h0, reg_r}, {24'h0, e.r});
                    check("retire_a", {24'h0, reg_a}, {24'h0, e.a});
                    check("retire_cycles", pgap, e.gap);
                end
            end
            if (instr_done === 1'b1) begin
                pend = 1'b1;
                pgap = cyc - last_cyc;
                last_cyc = cyc;
            end
        end
    end

    task automatic push_vec(input vec_t v);
        exp_t x;
        x.pc  = v.pc;
        x.r   = v.r;
        x.a   = v.a;
        x.gap = v.gap;
        stop  = v.stop;
        sb.push_back(x);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) return;
        end
        nvec++;
        nerr++;
        $display("FAIL drain_timeout: %0d retirements outstanding, expected 0", sb.size());
        sb.delete();
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        last_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_addr"},   {24'h0, mem_addr}, 32'h0);
        check({tag, "_mem_rw"},     {31'h0, mem_rw}, 32'h0);
        check({tag, "_pc"},         {24'h0, pc}, 32'h0);
        check({tag, "_ir"},         {22'h0, ir}, 32'h0);
        check({tag, "_reg_r"},      {24'h0, reg_r}, 32'h0);
        check({tag, "_reg_a"},      {24'h0, reg_a}, 32'h0);
        check({tag, "_busy"},       {31'h0, busy}, 32'h0);
        check({tag, "_instr_done"}, {31'h0, instr_done}, 32'h0);
        check({tag, "_halted"},     {31'h0, halted}, 32'h0);
    endtask

    initial begin
        vec_t v;
        logic [7:0] p;

        vecs[0] = '{1'b0, 8'h01, 8'h09, 8'h00, 2};
        vecs[1] = '{1'b0, 8'h02, 8'h09, 8'h9F, 2};
        vecs[2] = '{1'b0, 8'h03, 8'h09, 8'h77, 3};

        for (int i = 0; i < 256; i++) mem[i] = 10'h000;
        mem[0]  = 10'h109;
        mem[1]  = 10'h20A;
        mem[2]  = 10'h30B;
        mem[3]  = 10'h000;
        mem[10] = 10'h09F;
        mem[11] = 10'h00C;
        mem[12] = 10'h077;

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // MOVR, LDI, LDA back-to-back from reset
        push_vec(vecs[0]);
        kick();
        drain(20);
        for (int i = 1; i < 3; i++) begin
            push_vec(vecs[i]);
            drain(20);
        end

`ifdef MEM_CTRL_HALT_EN
        v = '{1'b0, 8'h04, 8'h09, 8'h77, 2};
        push_vec(v);
        drain(20);
        @(negedge clk);
        check("halt_halted", {31'h0, halted}, 32'h1);
        check("halt_busy", {31'h0, busy}, 32'h0);
        check("halt_mem_addr", {24'h0, mem_addr}, 32'h04);
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (4) @(negedge clk);
        check("halt_hold", {31'h0, halted}, 32'h1);
        check("halt_pc", {24'h0, pc}, 32'h04);
        check("halt_r", {24'h0, reg_r}, 32'h09);
        check("halt_a", {24'h0, reg_a}, 32'h77);
`else
        // Mem[3..255] are NOPs; pc wraps and Mem[0] runs again, then stop
        for (int k = 3; k < 256; k++) begin
            p = 8'(k + 1);
            v = '{1'b0, p, 8'h09, 8'h77, 2};
            push_vec(v);
            drain(10);
        end
        v = '{1'b1, 8'h01, 8'h09, 8'h77, 2};
        push_vec(v);
        drain(10);
        repeat (2) @(negedge clk);
        check("wrap_idle_busy", {31'h0, busy}, 32'h0);
        check("wrap_idle_pc", {24'h0, pc}, 32'h01);
        check("wrap_halted", {31'h0, halted}, 32'h0);
`endif

        // stop held: one instruction then IDLE, start resumes at Mem[1]
        do_reset();
        v = '{1'b1, 8'h01, 8'h09, 8'h00, 2};
        push_vec(v);
        kick();
        drain(20);
        repeat (3) @(negedge clk);
        check("stop_busy", {31'h0, busy}, 32'h0);
        check("stop_pc", {24'h0, pc}, 32'h01);
        check("stop_mem_addr", {24'h0, mem_addr}, 32'h01);
        v = '{1'b1, 8'h02, 8'h09, 8'h9F, 2};
        push_vec(v);
        kick();
        drain(20);

        // Reset during the LDA operand read
        do_reset();
        push_vec(vecs[0]);
        kick();
        drain(20);
        push_vec(vecs[1]);
        drain(20);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && pc === 8'h03 && mem_addr === 8'h0C) found = 1'b1;
        end
        if (!found) begin
            nvec++;
            nerr++;
            $display("FAIL lda_read_not_seen: no READ state within 10 cycles");
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_a_held", {24'h0, reg_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("mem_rw_nonzero_cycles", rw_bad, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
